aurora_rx_frame_checker: RTL and testbench



---
 rtl/aurora_rx_frame_checker.sv | 135 +++++++++++++
 tb/tb_aurora_rx_frame_checker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_rx_frame_checker.sv
// Aurora RX frame checker: checks each received AXI-Stream frame for length and
// content against exp_data, with saturating counters, sticky error and link watchdog.
//
// state  | meaning
// S_IDLE | no frame in progress; next accepted beat is word 0
// S_BODY | inside a frame, idx is the index of the next expected word
// S_DROP | frame already too long; discard beats until tlast
module aurora_rx_frame_checker #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 2,
  parameter int CNT_W     = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                          user_clk,
  input  logic                          sys_reset_n,
  input  logic                          s_axis_tvalid,
  input  logic [DATA_W-1:0]             s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  input  logic [FRAME_LEN*DATA_W-1:0]   exp_data,
  input  logic                          clr,
  output logic                          frame_done,
  output logic                          frame_good,
  output logic [CNT_W-1:0]              good_cnt,
  output logic [CNT_W-1:0]              bad_cnt,
  output logic                          err_sticky,
  output logic                          link_stale,
  output logic [DATA_W-1:0]             last_word
);
  localparam int IDX_W = $clog2(FRAME_LEN + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              frame_err;
  logic [WD_W-1:0]   wd_cnt;
  logic [DATA_W-1:0] exp_word;
  logic              beat;
  logic              word_ok;
  logic              fin;
  logic              fin_good;

  always_comb begin
    exp_word = '0;
    for (int i = 0; i < FRAME_LEN; i++)
      if (idx == IDX_W'(i)) exp_word = exp_data[i*DATA_W +: DATA_W];
    beat     = s_axis_tvalid & s_axis_tready;
    word_ok  = (s_axis_tdata == exp_word);
    fin      = beat & s_axis_tlast;
    fin_good = 1'b0;
    unique case (state)
      S_IDLE:  fin_good = (FRAME_LEN == 1) && word_ok;
      S_BODY:  fin_good = (idx == LAST_IDX) && !frame_err && word_ok;
      default: fin_good = 1'b0;
    endcase
    fin_good = fin_good & fin;
  end

  always_ff @(posedge user_clk) begin
    if (!sys_reset_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      frame_err     <= 1'b0;
      wd_cnt        <= '0;
      s_axis_tready <= 1'b0;
      frame_done    <= 1'b0;
      frame_good    <= 1'b0;
      good_cnt      <= '0;
      bad_cnt       <= '0;
      err_sticky    <= 1'b0;
      link_stale    <= 1'b0;
      last_word     <= '0;
    end else begin
      s_axis_tready <= 1'b1;
      frame_done    <= fin;
      frame_good    <= fin_good;

      if (beat) begin
        last_word <= s_axis_tdata;
        unique case (state)
          S_IDLE: begin
            if (!s_axis_tlast) begin
              idx       <= IDX_W'(1);
              frame_err <= !word_ok;
              state     <= S_BODY;
            end
          end
          S_BODY: begin
            if (s_axis_tlast) begin
              idx   <= '0;
              state <= S_IDLE;
            end else if (idx >= LAST_IDX) begin
              state <= S_DROP;
            end else begin
              idx       <= idx + 1'b1;
              frame_err <= frame_err | !word_ok;
            end
          end
          default: begin
            if (s_axis_tlast) begin
              idx   <= '0;
              state <= S_IDLE;
            end
          end
        endcase
      end

      // clear wins first, then the frame-end event of the same cycle is applied
      if (clr) begin
        good_cnt   <= CNT_W'(fin_good);
        bad_cnt    <= CNT_W'(fin && !fin_good);
        err_sticky <= fin && !fin_good;
      end else if (fin) begin
        if (fin_good) begin
          if (good_cnt != '1) good_cnt <= good_cnt + 1'b1;
        end else begin
          if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
          err_sticky <= 1'b1;
        end
      end

      if (clr || fin_good) begin
        wd_cnt     <= '0;
        link_stale <= 1'b0;
      end else begin
        if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt >= WD_MAX - 1'b1) link_stale <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_aurora_rx_frame_checker.sv
// Bench for aurora_rx_frame_checker: directed scenarios plus randomized frames,
// checked every cycle against a frame-level reference model.
module tb_aurora_rx_frame_checker;
  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 2;
  localparam int CNT_W     = 4;
  localparam int TIMEOUT   = 16;
  localparam int MAXC      = 2**CNT_W - 1;

  logic                        user_clk = 1'b0;
  logic                        sys_reset_n;
  logic                        s_axis_tvalid;
  logic [DATA_W-1:0]           s_axis_tdata;
  logic                        s_axis_tlast;
  logic                        s_axis_tready;
  logic [FRAME_LEN*DATA_W-1:0] exp_data;
  logic                        clr;
  logic                        frame_done;
  logic                        frame_good;
  logic [CNT_W-1:0]            good_cnt;
  logic [CNT_W-1:0]            bad_cnt;
  logic                        err_sticky;
  logic                        link_stale;
  logic [DATA_W-1:0]           last_word;

  logic [DATA_W-1:0] exp_w [FRAME_LEN];

  for (genvar g = 0; g < FRAME_LEN; g++) begin : g_exp
    assign exp_data[g*DATA_W +: DATA_W] = exp_w[g];
  end

  aurora_rx_frame_checker #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .user_clk(user_clk), .sys_reset_n(sys_reset_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .exp_data(exp_data), .clr(clr),
    .frame_done(frame_done), .frame_good(frame_good),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt),
    .err_sticky(err_sticky), .link_stale(link_stale), .last_word(last_word)
  );

  always #5 user_clk = ~user_clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [63:0] sat(input int n);
    return (n > MAXC) ? 64'(MAXC) : 64'(n);
  endfunction

  // Reference model: collects per-word match flags of the current frame and
  // judges the whole frame when tlast is accepted.
  bit                m_ready, m_done, m_good, m_sticky;
  int                n_good, n_bad, since;
  logic [DATA_W-1:0] m_lw;
  bit                frame_ok [$];

  always @(posedge user_clk) begin
    if (!sys_reset_n) begin
      m_ready = 0; m_done = 0; m_good = 0; m_sticky = 0;
      n_good = 0; n_bad = 0; since = 0; m_lw = '0;
      frame_ok.delete();
    end else begin
      bit ok;
      int p;
      m_done = 0;
      m_good = 0;
      if (clr) begin
        n_good = 0; n_bad = 0; m_sticky = 0;
      end
      if (s_axis_tvalid && m_ready) begin
        m_lw = s_axis_tdata;
        p  = frame_ok.size();
        ok = 0;
        if (p < FRAME_LEN) ok = (s_axis_tdata == exp_w[p]);
        frame_ok.push_back(ok);
        if (s_axis_tlast) begin
          m_done = 1;
          m_good = (frame_ok.size() == FRAME_LEN);
          foreach (frame_ok[i]) if (!frame_ok[i]) m_good = 0;
          if (m_good) n_good++;
          else begin
            n_bad++;
            m_sticky = 1;
          end
          frame_ok.delete();
        end
      end
      if (clr || m_good) since = 0;
      else since++;
      m_ready = 1;
    end
  end

  always @(negedge user_clk) begin
    if (chk_en) begin
      check_val("tready", 64'(s_axis_tready), 64'(m_ready));
      check_val("frame_done", 64'(frame_done), 64'(m_done));
      if (m_done) check_val("frame_good", 64'(frame_good), 64'(m_good));
      check_val("good_cnt", 64'(good_cnt), sat(n_good));
      check_val("bad_cnt", 64'(bad_cnt), sat(n_bad));
      check_val("err_sticky", 64'(err_sticky), 64'(m_sticky));
      check_val("link_stale", 64'(link_stale), 64'(since >= TIMEOUT));
      check_val("last_word", 64'(last_word), 64'(m_lw));
    end
  end

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic l, input logic c);
    @(negedge user_clk);
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = l; clr = c;
    @(posedge user_clk);
    #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge user_clk);
      s_axis_tvalid = 1'b0; s_axis_tdata = $urandom; s_axis_tlast = 1'($urandom); clr = 1'b0;
      @(posedge user_clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    @(negedge user_clk);
    clr = 1'b1;
    @(posedge user_clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge user_clk);
    sys_reset_n = 1'b0;
    repeat (n) @(posedge user_clk);
    @(negedge user_clk);
    sys_reset_n = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    int len;
    sys_reset_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; clr = 1'b0;
    exp_w[0] = 32'h5; exp_w[1] = 32'h3;
    repeat (3) @(posedge user_clk);
    @(negedge user_clk);
    chk_en = 1'b1;
    check_val("rst_tready", 64'(s_axis_tready), 64'd0);
    check_val("rst_last_word", 64'(last_word), 64'd0);
    sys_reset_n = 1'b1;

    // watchdog expires exactly TIMEOUT cycles after release
    repeat (TIMEOUT - 1) @(posedge user_clk);
    @(negedge user_clk);
    check_val("stale_early", 64'(link_stale), 64'd0);
    @(posedge user_clk);
    @(negedge user_clk);
    check_val("stale_set", 64'(link_stale), 64'd1);

    send_beat(32'h5, 1'b0, 1'b0);
    send_beat(32'h3, 1'b1, 1'b0);
    @(negedge user_clk);
    check_val("good_done", 64'(frame_done), 64'd1);
    check_val("good_good", 64'(frame_good), 64'd1);
    check_val("good_cnt1", 64'(good_cnt), 64'd1);
    check_val("good_lw", 64'(last_word), 64'h3);
    check_val("good_sticky", 64'(err_sticky), 64'd0);
    check_val("stale_clr", 64'(link_stale), 64'd0);

    pulse_clr();
    send_beat(32'h5, 1'b1, 1'b0);
    @(negedge user_clk);
    check_val("short_good", 64'(frame_good), 64'd0);
    check_val("short_bad", 64'(bad_cnt), 64'd1);
    check_val("short_sticky", 64'(err_sticky), 64'd1);
    send_beat(32'h5, 1'b0, 1'b0);
    send_beat(32'h3, 1'b1, 1'b0);
    @(negedge user_clk);
    check_val("after_short_good", 64'(good_cnt), 64'd1);
    check_val("sticky_holds", 64'(err_sticky), 64'd1);

    pulse_clr();
    send_beat(32'h5, 1'b0, 1'b0);
    send_beat(32'h3, 1'b0, 1'b0);
    send_beat(32'h7, 1'b0, 1'b0);
    send_beat(32'h9, 1'b1, 1'b0);
    @(negedge user_clk);
    check_val("long_done", 64'(frame_done), 64'd1);
    check_val("long_bad", 64'(bad_cnt), 64'd1);
    send_beat(32'h5, 1'b0, 1'b0);
    send_beat(32'h3, 1'b1, 1'b0);
    @(negedge user_clk);
    check_val("after_long_good", 64'(frame_good), 64'd1);
    check_val("after_long_cnt", 64'(good_cnt), 64'd1);

    pulse_clr();
    repeat (MAXC + 2) send_beat(32'h5, 1'b1, 1'b0);
    @(negedge user_clk);
    check_val("bad_sat", 64'(bad_cnt), 64'(MAXC));
    send_beat(32'h5, 1'b0, 1'b0);
    send_beat(32'h3, 1'b1, 1'b1);
    @(negedge user_clk);
    check_val("clr_evt_done", 64'(frame_done), 64'd1);
    check_val("clr_evt_good", 64'(good_cnt), 64'd1);
    check_val("clr_evt_bad", 64'(bad_cnt), 64'd0);
    check_val("clr_evt_sticky", 64'(err_sticky), 64'd0);

    send_beat(32'h5, 1'b0, 1'b0);
    do_reset(1);
    idle(2);
    send_beat(32'h5, 1'b0, 1'b0);
    send_beat(32'h3, 1'b1, 1'b0);
    @(negedge user_clk);
    check_val("midrst_good", 64'(good_cnt), 64'd1);
    check_val("midrst_bad", 64'(bad_cnt), 64'd0);

    for (int f = 0; f < 400; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        exp_w[0] = 32'($urandom_range(0, 7));
        exp_w[1] = 32'($urandom_range(0, 7));
      end
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : FRAME_LEN;
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 9) == 0 || b >= FRAME_LEN) d = 32'($urandom_range(0, 7));
        else d = exp_w[b];
        send_beat(d, b == len - 1, $urandom_range(0, 19) == 0);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(10, 25)));
      else idle(int'($urandom_range(0, 2)));
      if ($urandom_range(0, 49) == 0) begin
        send_beat(exp_w[0], 1'b0, 1'b0);
        do_reset(int'($urandom_range(1, 3)));
        idle(1);
      end
    end

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
